cpu_fetch: RTL and testbench
============================

Name: cpu_fetch

Overview:
- Instruction fetch unit for the moxie core; the producer side of the decoder's opcode_o/operand_o/valid_o/stall_i interface.
- Issues 32-bit word reads to instruction memory and buffers the returned halfwords in a prefetch queue.
- Assembles 16-bit or 48-bit instructions (opcode plus 32-bit operand) and presents one per cycle to cpu_decode.
- Honours the decode stall and redirects on branch.

Parameters:
QUEUE_DEPTH, 8, prefetch queue capacity in halfwords (power of 2, at least 4)
RESET_PC, 32'h00001000, fetch address after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-low
imem_req_o  out  1  read request, held until ack
imem_addr_o  out  32  word-aligned read address ([1:0]=0)
imem_ack_i  in  1  read data valid, at earliest the cycle after req is first asserted
imem_data_i  in  32  big-endian: [31:16] = halfword at addr, [15:0] = halfword at addr+2
branch_i  in  1  redirect strobe
branch_target_i  in  32  new PC, halfword aligned
stall_i  in  1  decode stall
opcode_o  out  16  instruction halfword to decode
operand_o  out  32  immediate for long forms; 0 for short forms
valid_o  out  1  opcode_o/operand_o valid
pc_o  out  32  address of opcode_o

Behaviour:
- Reset (rst_i=0 at an edge): valid_o=0, opcode_o=0, operand_o=0, pc_o=0, imem_req_o=0. Queue is emptied and the outstanding request is cleared. Fetch address = RESET_PC & ~3. Skip flag = RESET_PC[1].
- Memory returns acks only for requests it has seen since reset; an ack with no request outstanding is ignored.
- Request FSM, states IDLE and WAIT:
  - IDLE -> WAIT when queue count <= QUEUE_DEPTH-2 and branch_i=0. Drive imem_req_o=1 and imem_addr_o=fetch address.
  - In WAIT, req and addr stay stable until imem_ack_i.
  - On ack, push both halfwords, or only [15:0] if the skip flag is set, then clear skip. Fetch address += 4. Return to IDLE.
  - Only one request is outstanding at a time.
- Long instruction: opcode[15:8] in {01,03,08,09,0C,0D,1A,1B,1D,1F,20,22,24,36,37,38,39}. Every other opcode, including all with bit15=1, is short.
- Output register:
  - Loads when (!valid_o || !stall_i) and branch_i=0.
  - If the queue head is short and count >= 1: pop 1 halfword. opcode_o=head, operand_o=0, pc_o=head_pc, valid_o=1. head_pc += 2.
  - If the queue head is long and count >= 3: pop 3 halfwords. operand_o={hw1,hw2}. head_pc += 6.
  - Otherwise valid_o=0.
  - When stall_i=1 and valid_o=1, all outputs hold and nothing is popped.
- Push and pop in the same cycle are legal; the count updates by push-pop. The queue never overflows because of the issue rule.
- Latency: ack at edge N; a short instruction appears with valid_o=1 after edge N+1. A long instruction is valid the cycle after its third halfword is pushed.
- Branch (branch_i=1 at edge N):
  - Takes priority over stall and push.
  - After edge N: valid_o=0, queue empty, head_pc=target, fetch address=target & ~3, skip=target[1].
  - If a request is outstanding, set a kill flag. The next ack is discarded and clears kill; FSM goes to IDLE. A new request issues on the following edge.
  - If no request is outstanding, the new request issues at edge N+1.
  - A second branch while kill is set only updates the target; kill stays set.
- Wrap-around: address arithmetic is modulo 2^32.

Decomposition:
- defines.v gains `FETCH_RESET_PC and the long-opcode predicate, as a shared include function is_long_op(opcode[15:8]). cpu_decode and the assembler use the same list.
- Sub-module cpu_fetch_queue: halfword FIFO with 0/1/2-halfword push and 0/1/3-halfword pop, a flush input, and peek of head..head+2 and count.
- The FSM and output register stay in cpu_fetch.

Test Plan:
- Reset, mem[1000]=0120DEAD, mem[1004]=BEEF0000 -> first valid has opcode_o=0120, operand_o=DEADBEEF, pc_o=1000; next valid has opcode_o=0000, pc_o=1006.
- mem[1000]=05128305 -> two consecutive valid cycles: opcode_o=0512 with pc_o=1000, then opcode_o=8305 with pc_o=1002, operand_o=0 in both.
- stall_i=1 for 3 cycles while valid_o=1 with opcode_o=0512 -> outputs unchanged, queue count unchanged or rising. Release -> opcode_o=8305 the next cycle.
- branch_i with target 2002 while a request to 1008 is outstanding -> the 1008 data is discarded; next imem_addr_o=2000; upper halfword dropped; first valid pc_o=2002 with the mem[2000][15:0] opcode.
- stall_i held and immediate acks -> imem_req_o stops once count > QUEUE_DEPTH-2 (count never exceeds 8). Release stall -> fetching resumes with no lost or duplicated halfwords (pc_o increments contiguously).
- rst_i=0 for one edge during WAIT -> all outputs zero. The next request is to 1000, and decode restarts at pc_o=1000.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared definitions for the moxie instruction fetch unit.
//   FETCH_RESET_PC - default fetch address after reset
//   fetch_state_t  - request FSM states (one read outstanding at most)
//   is_long_op()   - true when an opcode's upper byte selects a 48-bit form
//                    (opcode + 32-bit operand); decode and the assembler use
//                    the same list.
package cpu_fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_1000;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } fetch_state_t;

  // Anything not in this list, including every opcode with bit 15 set,
  // is a 16-bit short form.
  function automatic logic is_long_op(input logic [7:0] op);
    case (op)
      8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
      8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39:
        is_long_op = 1'b1;
      default:
        is_long_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue: halfword prefetch FIFO.
//   clk, rst_n     - clock, synchronous active-low reset
//   flush          - empty the queue (wins over push and pop)
//   push_cnt       - 0/1/2 halfwords written this cycle
//   push_first     - halfword written at the tail
//   push_second    - halfword written behind it when push_cnt == 2
//   pop_cnt        - 0/1/3 halfwords removed from the head this cycle
//   head0..head2   - peek of the three oldest entries
//   count          - number of valid halfwords
module cpu_fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [1:0]               push_cnt,
  input  logic [15:0]              push_first,
  input  logic [15:0]              push_second,
  input  logic [1:0]               pop_cnt,
  output logic [15:0]              head0,
  output logic [15:0]              head1,
  output logic [15:0]              head2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_cnt);
      rd_ptr <= rd_ptr + AW'(pop_cnt);
      count  <= count + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  // Storage needs no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem[wr_ptr] <= push_first;
    if (push_cnt == 2'd2) mem[wr_ptr + AW'(1)] <= push_second;
  end

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + AW'(1)];
  assign head2 = mem[rd_ptr + AW'(2)];

endmodule

// File: rtl/cpu_fetch.sv
// cpu_fetch: instruction fetch unit for the moxie core.
//   clk_i, rst_i            - clock, synchronous active-low reset
//   imem_req_o/imem_addr_o  - word read request, held stable until ack
//   imem_ack_i/imem_data_i  - read data, big-endian halfword pair
//   branch_i/branch_target_i- redirect to a halfword-aligned PC
//   stall_i                 - decode cannot accept a new instruction
//   opcode_o/operand_o      - assembled instruction (operand 0 for short forms)
//   valid_o/pc_o            - instruction valid and its address
module cpu_fetch
  import cpu_fetch_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = FETCH_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  output logic [15:0] opcode_o,
  output logic [31:0] operand_o,
  output logic        valid_o,
  output logic [31:0] pc_o
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] ISSUE_LIMIT = CW'(QUEUE_DEPTH - 2);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic          issue;
  logic          take;
  logic [31:0]   fetch_addr;
  logic [31:0]   req_addr;
  logic [31:0]   head_pc;
  logic          skip;
  logic          kill;
  logic [1:0]    push_cnt;
  logic [15:0]   push_first;
  logic [1:0]    pop_cnt;
  logic [15:0]   head0;
  logic [15:0]   head1;
  logic [15:0]   head2;
  logic [CW-1:0] count;
  logic          load;
  logic          head_long;
  logic          can_short;
  logic          can_long;

  cpu_fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) queue (
    .clk         (clk_i),
    .rst_n       (rst_i),
    .flush       (branch_i),
    .push_cnt    (push_cnt),
    .push_first  (push_first),
    .push_second (imem_data_i[15:0]),
    .pop_cnt     (pop_cnt),
    .head0       (head0),
    .head1       (head1),
    .head2       (head2),
    .count       (count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= S_IDLE;
    else        state <= state_next;
  end

  // Issuing only with two free slots guarantees an ack can always be pushed.
  // An ack that arrives while kill is set, or together with a branch,
  // belongs to a stale address and is dropped.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    take       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!branch_i && count <= ISSUE_LIMIT) begin
          issue      = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack_i) begin
          state_next = S_IDLE;
          take       = !kill && !branch_i;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign imem_req_o  = (state == S_WAIT);
  assign imem_addr_o = req_addr;

  // A set skip flag means the fetch started at the odd halfword of the word.
  assign push_cnt   = take ? (skip ? 2'd1 : 2'd2) : 2'd0;
  assign push_first = skip ? imem_data_i[15:0] : imem_data_i[31:16];

  always_comb begin
    head_long = is_long_op(head0[15:8]);
    can_short = !head_long && (count >= CW'(1));
    can_long  = head_long && (count >= CW'(3));
    load      = (!valid_o || !stall_i) && !branch_i;
    pop_cnt   = 2'd0;
    if (load) begin
      if (can_short)     pop_cnt = 2'd1;
      else if (can_long) pop_cnt = 2'd3;
    end
  end

  // req_addr is captured at issue so a branch during WAIT cannot disturb
  // the address the memory is still working on.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_addr <= RESET_PC & ~32'h3;
      skip       <= RESET_PC[1];
      kill       <= 1'b0;
      req_addr   <= '0;
    end else begin
      if (issue) req_addr <= fetch_addr;
      if (branch_i) begin
        fetch_addr <= branch_target_i & ~32'h3;
        skip       <= branch_target_i[1];
      end else if (take) begin
        fetch_addr <= fetch_addr + 32'd4;
        skip       <= 1'b0;
      end
      if (state == S_WAIT && imem_ack_i) kill <= 1'b0;
      else if (state == S_WAIT && branch_i) kill <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_o   <= 1'b0;
      opcode_o  <= '0;
      operand_o <= '0;
      pc_o      <= '0;
      head_pc   <= RESET_PC;
    end else if (branch_i) begin
      valid_o <= 1'b0;
      head_pc <= branch_target_i;
    end else if (load) begin
      if (can_short) begin
        valid_o   <= 1'b1;
        opcode_o  <= head0;
        operand_o <= '0;
        pc_o      <= head_pc;
        head_pc   <= head_pc + 32'd2;
      end else if (can_long) begin
        valid_o   <= 1'b1;
        opcode_o  <= head0;
        operand_o <= {head1, head2};
        pc_o      <= head_pc;
        head_pc   <= head_pc + 32'd6;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: directed testbench for cpu_fetch with a behavioural
// instruction memory that acks each request after ack_delay idle cycles.
module tb_cpu_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        stall_i;
  logic [15:0] opcode_o;
  logic [31:0] operand_o;
  logic        valid_o;
  logic [31:0] pc_o;

  int errors = 0;
  int checks = 0;
  int ack_delay = 1;
  int wait_cnt = 0;
  logic [31:0] mem [logic [31:0]];

  cpu_fetch dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_data_i     (imem_data_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .stall_i         (stall_i),
    .opcode_o        (opcode_o),
    .operand_o       (operand_o),
    .valid_o         (valid_o),
    .pc_o            (pc_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] read_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Memory responder: one-cycle ack pulse after ack_delay cycles of request.
  initial begin
    imem_ack_i  = 1'b0;
    imem_data_i = 32'h0;
    forever begin
      @(negedge clk_i);
      if (imem_ack_i) begin
        imem_ack_i = 1'b0;
      end else if (imem_req_o === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          imem_ack_i  = 1'b1;
          imem_data_i = read_mem(imem_addr_o);
          wait_cnt    = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic stall, input logic branch,
                               input logic [31:0] target, input int cycles);
    rst_i           = rst;
    stall_i         = stall;
    branch_i        = branch;
    branch_target_i = target;
    repeat (cycles) @(negedge clk_i);
  endtask

  task automatic nextValid(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (valid_o !== 1'b1 && n < 100);
    checkOutput({tag, "_valid"}, 32'(valid_o), 32'h1);
  endtask

  task automatic waitReqRise(input string tag);
    int n;
    n = 0;
    while (imem_req_o !== 1'b0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    n = 0;
    while (imem_req_o !== 1'b1 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput({tag, "_req"}, 32'(imem_req_o), 32'h1);
  endtask

  task automatic waitReqAddr(input string tag, input logic [31:0] addr);
    int n;
    n = 0;
    while (!(imem_req_o === 1'b1 && imem_addr_o === addr) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput(tag, imem_addr_o, addr);
  endtask

  initial begin
    $display("[TB] cpu_fetch directed test start");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);

    // Long instruction spanning two memory words, then a short nop
    mem.delete();
    mem[32'h1000] = 32'h0120_DEAD;
    mem[32'h1004] = 32'hBEEF_0000;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2);
    checkOutput("rst_valid",   32'(valid_o),    32'h0);
    checkOutput("rst_opcode",  32'(opcode_o),   32'h0);
    checkOutput("rst_operand", operand_o,       32'h0);
    checkOutput("rst_pc",      pc_o,            32'h0);
    checkOutput("rst_req",     32'(imem_req_o), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 0);
    nextValid("long");
    checkOutput("long_opcode",  32'(opcode_o), 32'h0000_0120);
    checkOutput("long_operand", operand_o,     32'hDEAD_BEEF);
    checkOutput("long_pc",      pc_o,          32'h0000_1000);
    nextValid("after_long");
    checkOutput("after_long_opcode",  32'(opcode_o), 32'h0);
    checkOutput("after_long_operand", operand_o,     32'h0);
    checkOutput("after_long_pc",      pc_o,          32'h0000_1006);

    // Two short instructions from one word on consecutive cycles
    mem.delete();
    mem[32'h1000] = 32'h0512_8305;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 0);
    nextValid("short1");
    checkOutput("short1_opcode",  32'(opcode_o), 32'h0000_0512);
    checkOutput("short1_operand", operand_o,     32'h0);
    checkOutput("short1_pc",      pc_o,          32'h0000_1000);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
    checkOutput("short2_valid",   32'(valid_o),  32'h1);
    checkOutput("short2_opcode",  32'(opcode_o), 32'h0000_8305);
    checkOutput("short2_operand", operand_o,     32'h0);
    checkOutput("short2_pc",      pc_o,          32'h0000_1002);

    // Stall holds the presented instruction
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 0);
    nextValid("stall_first");
    checkOutput("stall_first_opcode", 32'(opcode_o), 32'h0000_0512);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
      checkOutput("stall_hold_valid",  32'(valid_o),  32'h1);
      checkOutput("stall_hold_opcode", 32'(opcode_o), 32'h0000_0512);
      checkOutput("stall_hold_pc",     pc_o,          32'h0000_1000);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
    checkOutput("stall_release_valid",  32'(valid_o),  32'h1);
    checkOutput("stall_release_opcode", 32'(opcode_o), 32'h0000_8305);
    checkOutput("stall_release_pc",     pc_o,          32'h0000_1002);

    // Branch to an odd halfword while the 1008 read is outstanding
    mem[32'h1008] = 32'h7000_7001;
    mem[32'h2000] = 32'h7777_0400;
    ack_delay = 3;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 0);
    waitReqAddr("kill_req_1008", 32'h0000_1008);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_2002, 1);
    checkOutput("branch_valid", 32'(valid_o), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 0);
    waitReqRise("redirect");
    checkOutput("redirect_addr", imem_addr_o, 32'h0000_2000);
    nextValid("redirect");
    checkOutput("redirect_pc",      pc_o,          32'h0000_2002);
    checkOutput("redirect_opcode",  32'(opcode_o), 32'h0000_0400);
    checkOutput("redirect_operand", operand_o,     32'h0);
    nextValid("redirect_next");
    checkOutput("redirect_next_pc", pc_o, 32'h0000_2004);

    // Back-pressure: stalled decode with fast memory fills the queue
    ack_delay = 1;
    mem.delete();
    for (int i = 0; i < 16; i++)
      mem[32'h1000 + 32'(4 * i)] = {16'h8000 | 16'(2 * i), 16'h8000 | 16'(2 * i + 1)};
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 0);
    nextValid("bp_first");
    checkOutput("bp_first_opcode", 32'(opcode_o), 32'h0000_8000);
    checkOutput("bp_first_pc",     pc_o,          32'h0000_1000);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 40);
    checkOutput("bp_req_stopped", 32'(imem_req_o), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    checkOutput("bp_req_still_stopped", 32'(imem_req_o), 32'h0);
    checkOutput("bp_hold_opcode",       32'(opcode_o),   32'h0000_8000);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 0);
    for (int i = 1; i <= 12; i++) begin
      nextValid("bp_seq");
      checkOutput("bp_seq_pc",     pc_o,          32'h0000_1000 + 32'(2 * i));
      checkOutput("bp_seq_opcode", 32'(opcode_o), 32'h0000_8000 | 32'(i));
    end

    // Reset while a read is outstanding restarts cleanly at the reset PC
    ack_delay = 3;
    mem.delete();
    mem[32'h1000] = 32'h0512_8305;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 0);
    waitReqAddr("midrst_req_1008", 32'h0000_1008);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1);
    checkOutput("midrst_valid",   32'(valid_o),    32'h0);
    checkOutput("midrst_opcode",  32'(opcode_o),   32'h0);
    checkOutput("midrst_operand", operand_o,       32'h0);
    checkOutput("midrst_pc",      pc_o,            32'h0);
    checkOutput("midrst_req",     32'(imem_req_o), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 0);
    waitReqRise("restart");
    checkOutput("restart_addr", imem_addr_o, 32'h0000_1000);
    nextValid("restart");
    checkOutput("restart_pc",     pc_o,          32'h0000_1000);
    checkOutput("restart_opcode", 32'(opcode_o), 32'h0000_0512);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
